// File: rtl/counter.sv
// Free-running up-counter with count enable and one-cycle wrap flag.
// count, overflow (and parity when built with COUNTER_PARITY_EN) are registered outputs.
// Optional feature macro: COUNTER_PARITY_EN adds a registered parity output equal to ^count.
module counter #(
   parameter int unsigned bits = 4
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            enable,
   output logic [bits-1:0] count,
`ifdef COUNTER_PARITY_EN
   output logic            parity,
`endif
   output logic            overflow
);

   localparam logic [bits-1:0] LP_ONE = bits'(1);

   logic [bits-1:0] r_count;
   logic            r_overflow;
   logic [bits-1:0] w_count_d;
   logic            w_overflow_d;
   logic            w_at_max;

   // Next-state: increment modulo 2**bits; carry is dropped and only reported via overflow.
   always_comb begin
      w_at_max     = &r_count;
      w_count_d    = r_count;
      w_overflow_d = 1'b0;
      if (enable) begin
         w_count_d    = r_count + LP_ONE;
         w_overflow_d = w_at_max;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_count    <= w_count_d;
         r_overflow <= w_overflow_d;
      end
   end

`ifdef COUNTER_PARITY_EN
   logic r_parity;
   logic w_parity_d;

   // Parity tracks the next count so it lands on the same edge as count.
   always_comb begin
      w_parity_d = ^w_count_d;
   end

   // Parity register, cleared with the counter.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_parity <= 1'b0;
      end else begin
         r_parity <= w_parity_d;
      end
   end

   assign parity = r_parity;
`endif

   assign count    = r_count;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter (bits=4, 10 ns clock).
// Reference model: number of enabled edges since reset; expected count is that number
// modulo 16, and overflow is set when the last edge was enabled and landed on a multiple of 16.
module tb_counter;

   localparam int BITS = 4;
   localparam int MOD  = 1 << BITS;

   logic            CLK = 1'b0;
   logic            reset;
   logic            enable;
   logic [BITS-1:0] count;
   logic            overflow;
`ifdef COUNTER_PARITY_EN
   logic            parity;
`endif

   int checks = 0;
   int errors = 0;

   // Model state
   int unsigned n_en;
   bit          last_en;

   always #5 CLK = ~CLK;

   counter #(.bits(BITS)) dut (
      .CLK      (CLK),
      .reset    (reset),
      .enable   (enable),
      .count    (count),
`ifdef COUNTER_PARITY_EN
      .parity   (parity),
`endif
      .overflow (overflow)
   );

   function automatic logic [BITS-1:0] exp_count();
      return BITS'(n_en % MOD);
   endfunction

   function automatic logic exp_ov();
      return last_en && (n_en > 0) && ((n_en % MOD) == 0);
   endfunction

   // Drive enable for one edge, update the model, return at the following negedge.
   task automatic tick(input bit en);
      enable = en;
      @(posedge CLK);
      if (reset) begin
         if (en) n_en++;
         last_en = en;
      end
      @(negedge CLK);
   endtask

   task automatic model_clear();
      n_en    = 0;
      last_en = 0;
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      enable = 1'b1;
      model_clear();
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK);
         #2;
         checks++;
         if (count !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: count=%0d overflow=%b, required count=0 overflow=0",
                     count, overflow);
         end
`ifdef COUNTER_PARITY_EN
         checks++;
         if (parity !== 1'b0) begin
            errors++;
            $display("FAIL reset_parity: parity=%b, required 0", parity);
         end
`endif
      end
      @(negedge CLK);
      reset = 1'b1;
   endtask

   task automatic test_count_up();
      for (int i = 1; i <= 15; i++) begin
         tick(1'b1);
         checks++;
         if (count !== exp_count() || overflow !== 1'b0 || count !== BITS'(i)) begin
            errors++;
            $display("FAIL count_up edge %0d: count=%0d overflow=%b, required count=%0d overflow=0",
                     i, count, overflow, i);
         end
`ifdef COUNTER_PARITY_EN
         checks++;
         if (parity !== ^exp_count()) begin
            errors++;
            $display("FAIL count_up_parity: parity=%b, required %b", parity, ^exp_count());
         end
`endif
      end
   endtask

   task automatic test_wrap();
      tick(1'b1);
      checks++;
      if (count !== 4'd0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL wrap_edge16: count=%0d overflow=%b, required count=0 overflow=1",
                  count, overflow);
      end
      tick(1'b1);
      checks++;
      if (count !== 4'd1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL wrap_edge17: count=%0d overflow=%b, required count=1 overflow=0",
                  count, overflow);
      end
      // Second lap: overflow only on the edge that lands on 0.
      for (int i = 0; i < 15; i++) begin
         tick(1'b1);
         checks++;
         if (count !== exp_count() || overflow !== exp_ov()) begin
            errors++;
            $display("FAIL wrap_repeat: count=%0d overflow=%b, required count=%0d overflow=%b",
                     count, overflow, exp_count(), exp_ov());
         end
      end
      checks++;
      if (count !== 4'd0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL wrap_edge32: count=%0d overflow=%b, required count=0 overflow=1",
                  count, overflow);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 7; i++) tick(1'b1);
      for (int i = 0; i < 5; i++) begin
         tick(1'b0);
         checks++;
         if (count !== 4'd7 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL hold: count=%0d overflow=%b, required count=7 overflow=0",
                     count, overflow);
         end
`ifdef COUNTER_PARITY_EN
         checks++;
         if (parity !== 1'b1) begin
            errors++;
            $display("FAIL hold_parity: parity=%b at count 7, required 1", parity);
         end
`endif
      end
      tick(1'b1);
      checks++;
      if (count !== 4'd8 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL hold_resume: count=%0d overflow=%b, required count=8 overflow=0",
                  count, overflow);
      end
   endtask

   task automatic test_hold_at_max();
      for (int i = 0; i < 7; i++) tick(1'b1);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0);
         checks++;
         if (count !== 4'd15 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL hold_max: count=%0d overflow=%b, required count=15 overflow=0",
                     count, overflow);
         end
      end
      tick(1'b1);
      checks++;
      if (count !== 4'd0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL hold_max_wrap: count=%0d overflow=%b, required count=0 overflow=1",
                  count, overflow);
      end
   endtask

   // Assert reset between edges while overflow is high; outputs must clear before the next edge.
   task automatic test_async_mid();
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: overflow=%b, required 1", overflow);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (count !== '0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL async_mid: count=%0d overflow=%b, required count=0 overflow=0",
                  count, overflow);
      end
      @(negedge CLK);
      model_clear();
      reset = 1'b1;
   endtask

   task automatic test_random();
      logic [BITS-1:0] e;
      for (int i = 0; i < 400; i++) begin
         tick(($urandom % 4) != 0);
         e = exp_count();
         checks++;
         if (count !== e || overflow !== exp_ov()) begin
            errors++;
            $display("FAIL random step %0d: count=%0d overflow=%b, required count=%0d overflow=%b",
                     i, count, overflow, e, exp_ov());
         end
`ifdef COUNTER_PARITY_EN
         checks++;
         if (parity !== ^e) begin
            errors++;
            $display("FAIL random_parity: parity=%b, required %b", parity, ^e);
         end
`endif
         if (($urandom % 60) == 0) begin
            #2;
            reset = 1'b0;
            #1;
            checks++;
            if (count !== '0 || overflow !== 1'b0) begin
               errors++;
               $display("FAIL random_reset: count=%0d overflow=%b, required 0/0",
                        count, overflow);
            end
            @(negedge CLK);
            model_clear();
            reset = 1'b1;
         end
      end
   endtask

   initial begin
      reset  = 1'b0;
      enable = 1'b0;
      model_clear();
      @(negedge CLK);
      test_reset();
      test_count_up();
      test_wrap();
      test_hold();
      test_hold_at_max();
      test_async_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
